// File: rtl/led_scan_pkg.sv
// Shared constants and types for the LED matrix scan controller.
`timescale 1ns/1ps
package led_scan_pkg;

   localparam int unsigned DATA_W          = 16;
   localparam int unsigned ADDR_CTRL       = 16;
   localparam int unsigned ADDR_STATUS     = 17;

   localparam int unsigned CTRL_ENABLE_BIT = 0;
   localparam int unsigned CTRL_SWAP_BIT   = 1;

   localparam int unsigned STAT_PEND_BIT   = 0;
   localparam int unsigned STAT_ROW_LSB    = 4;
   localparam int unsigned STAT_BANK_BIT   = 8;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } scan_state_t;

endpackage

// File: rtl/led_scan_timer.sv
// Scan sequencer: blank/drive FSM, phase counter and row counter.
`timescale 1ns/1ps
module led_scan_timer
   import led_scan_pkg::*;
#(
   parameter int unsigned ROW_CYCLES   = 5000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   output scan_state_t state_c,
   output logic [3:0]  row,
   output logic        load_c,
   output logic        start_c,
   output logic        boundary_c
);

   localparam int unsigned MAX_CYC = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
   localparam int unsigned PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   scan_state_t     state_q;
   logic [PH_W-1:0] phase_q, phase_d;
   logic [3:0]      row_q, row_d;

   assign row = row_q;

   // State, phase and row registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         phase_q <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_c;
         phase_q <= phase_d;
         row_q   <= row_d;
      end
   end

   // Next-state logic; a cleared enable forces IDLE from any state
   always_comb begin
      state_c    = state_q;
      phase_d    = phase_q + PH_W'(1);
      row_d      = row_q;
      load_c     = 1'b0;
      start_c    = 1'b0;
      boundary_c = 1'b0;
      if (!enable) begin
         state_c = IDLE;
         phase_d = '0;
         row_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_c = BLANK;
               phase_d = '0;
               row_d   = '0;
               start_c = 1'b1;
            end
            BLANK: begin
               if (phase_q == PH_W'(BLANK_CYCLES - 1)) begin
                  state_c = DRIVE;
                  phase_d = '0;
                  load_c  = 1'b1;
               end
            end
            DRIVE: begin
               if (phase_q == PH_W'(ROW_CYCLES - 1)) begin
                  state_c = BLANK;
                  phase_d = '0;
                  row_d   = row_q + 4'd1;
                  if (row_q == 4'd15) begin
                     boundary_c = 1'b1;
                     start_c    = 1'b1;
                  end
               end
            end
            default: begin
               state_c = IDLE;
               phase_d = '0;
               row_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Avalon-MM double-buffered 16x16 LED frame store with autonomous row scan.
`timescale 1ns/1ps
module led_matrix_scan_ctrl
   import led_scan_pkg::*;
#(
   parameter int unsigned ROW_CYCLES   = 5000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic [15:0] row_sel,
   output logic [15:0] col_data,
   output logic        frame_start
);

   logic [DATA_W-1:0] bank [2][16];
   logic              enable;
   logic              swap_pending;
   logic              bank_sel;

   scan_state_t       state_c;
   logic [3:0]        row;
   logic              load_c, start_c, boundary_c;

   logic              wr, wr_row, wr_ctrl, swap_now;
   logic [DATA_W-1:0] front_word;

   assign wr         = chipselect && !write_n;
   assign wr_row     = wr && !address[4];
   assign wr_ctrl    = wr && (address == 5'(ADDR_CTRL));
   assign swap_now   = boundary_c && swap_pending;
   assign front_word = bank[bank_sel][row];

   led_scan_timer #(
      .ROW_CYCLES   (ROW_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .state_c    (state_c),
      .row        (row),
      .load_c     (load_c),
      .start_c    (start_c),
      .boundary_c (boundary_c)
   );

   // Row writes always land in the bank that is back before any swap this edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 16; r++) begin
               bank[b][r] <= '0;
            end
         end
      end else if (wr_row) begin
         bank[~bank_sel][address[3:0]] <= writedata;
      end
   end

   // Control state; a swap write in the boundary cycle re-arms pending after the swap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable       <= 1'b0;
         swap_pending <= 1'b0;
         bank_sel     <= 1'b0;
      end else begin
         if (swap_now) begin
            bank_sel <= ~bank_sel;
         end
         if (wr_ctrl) begin
            enable <= writedata[CTRL_ENABLE_BIT];
         end
         if (wr_ctrl && writedata[CTRL_SWAP_BIT]) begin
            swap_pending <= 1'b1;
         end else if (swap_now) begin
            swap_pending <= 1'b0;
         end
      end
   end

   // Matrix drive registers; the column word is captured once per row at drive start
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_sel     <= '0;
         col_data    <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= start_c;
         if (state_c != DRIVE) begin
            row_sel  <= '0;
            col_data <= '0;
         end else if (load_c) begin
            row_sel  <= 16'd1 << row;
            col_data <= front_word;
         end
      end
   end

   // Zero-wait-state read mux
   always_comb begin
      readdata = '0;
      if (!address[4]) begin
         readdata = bank[~bank_sel][address[3:0]];
      end else if (address == 5'(ADDR_CTRL)) begin
         readdata[CTRL_ENABLE_BIT] = enable;
      end else if (address == 5'(ADDR_STATUS)) begin
         readdata[STAT_PEND_BIT]       = swap_pending;
         readdata[STAT_ROW_LSB +: 4]   = row;
         readdata[STAT_BANK_BIT]       = bank_sel;
      end
   end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Self-checking bench for led_matrix_scan_ctrl with a frame-timing reference model.
`timescale 1ns/1ps
module tb_led_matrix_scan_ctrl;

   localparam int RC  = 4;
   localparam int BC  = 2;
   localparam int PER = RC + BC;
   localparam int FRM = 16 * PER;

   logic        clk;
   logic        reset_n;
   logic [4:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic [15:0] row_sel;
   logic [15:0] col_data;
   logic        frame_start;

   led_matrix_scan_ctrl #(
      .ROW_CYCLES   (RC),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .row_sel     (row_sel),
      .col_data    (col_data),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: scan position is cycles elapsed since the scan started
   int          m_k;
   bit          m_en, m_pend, m_sel;
   logic [15:0] m_bank [2][16];
   logic [15:0] m_latch;
   logic [15:0] e_rs, e_col;
   bit          e_fs;

   typedef struct {
      bit          wr;
      logic [4:0]  addr;
      logic [15:0] data;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl [16];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
   endtask

   task automatic model_reset();
      m_k = -1; m_en = 0; m_pend = 0; m_sel = 0; m_latch = '0;
      e_rs = '0; e_col = '0; e_fs = 0;
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 16; r++)
            m_bank[b][r] = '0;
   endtask

   function automatic int m_row();
      return (m_k < 0) ? 0 : (m_k / PER) % 16;
   endfunction

   function automatic logic [15:0] model_rd(input logic [4:0] a);
      logic [15:0] v;
      v = '0;
      if (a < 16) v = m_bank[!m_sel][a[3:0]];
      else if (a == 16) v[0] = m_en;
      else if (a == 17) begin
         v[0]   = m_pend;
         v[7:4] = 4'(m_row());
         v[8]   = m_sel;
      end
      return v;
   endfunction

   task automatic model_step();
      bit wr, bnd;
      int nk, ph, r;
      wr  = chipselect && !write_n;
      bnd = m_en && (m_k >= 0) && ((m_k % FRM) == FRM - 1);
      nk  = m_en ? m_k + 1 : -1;
      if (wr && address < 16) m_bank[!m_sel][address[3:0]] = writedata;
      if (bnd && m_pend) begin
         m_sel  = !m_sel;
         m_pend = 0;
      end
      if (wr && address == 16) begin
         m_en = writedata[0];
         if (writedata[1]) m_pend = 1;
      end
      m_k  = nk;
      e_fs = 0; e_rs = '0; e_col = '0;
      if (nk >= 0) begin
         ph   = nk % PER;
         r    = (nk / PER) % 16;
         e_fs = ((nk % FRM) == 0);
         if (ph == BC) m_latch = m_bank[m_sel][r];
         if (ph >= BC) begin
            e_rs  = 16'(1) << r;
            e_col = m_latch;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      check("scan_out", {row_sel, col_data}, {e_rs, e_col});
      check("frame_start", {31'b0, frame_start}, {31'b0, e_fs});
   endtask

   task automatic bus_idle();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      bus_idle();
   endtask

   task automatic read_chk(input logic [4:0] a, input string nm, input logic [15:0] exp);
      address = a;
      #1;
      check(nm, {16'b0, readdata}, {16'b0, exp});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fs_n, nz1, nz2;
      int fs_t [4];
      bit found;

      tbl[0]  = '{1'b0, 5'd0,  16'h0000, 16'h0000};
      tbl[1]  = '{1'b0, 5'd16, 16'h0000, 16'h0000};
      tbl[2]  = '{1'b0, 5'd17, 16'h0000, 16'h0000};
      tbl[3]  = '{1'b0, 5'd20, 16'h0000, 16'h0000};
      tbl[4]  = '{1'b1, 5'd20, 16'hFFFF, 16'h0000};
      tbl[5]  = '{1'b0, 5'd20, 16'h0000, 16'h0000};
      tbl[6]  = '{1'b0, 5'd16, 16'h0000, 16'h0000};
      tbl[7]  = '{1'b0, 5'd17, 16'h0000, 16'h0000};
      tbl[8]  = '{1'b1, 5'd5,  16'hA5A5, 16'h0000};
      tbl[9]  = '{1'b0, 5'd5,  16'h0000, 16'hA5A5};
      tbl[10] = '{1'b0, 5'd4,  16'h0000, 16'h0000};
      tbl[11] = '{1'b1, 5'd16, 16'h0002, 16'h0000};
      tbl[12] = '{1'b0, 5'd16, 16'h0000, 16'h0000};
      tbl[13] = '{1'b0, 5'd17, 16'h0000, 16'h0001};
      tbl[14] = '{1'b1, 5'd16, 16'h0000, 16'h0000};
      tbl[15] = '{1'b0, 5'd17, 16'h0000, 16'h0001};

      address = '0; writedata = '0;
      bus_idle();
      do_reset();
      check("reset_outputs", {row_sel, col_data}, 32'h0);
      check("reset_fs", {31'b0, frame_start}, 32'h0);

      // Register access vectors while idle
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
         else begin
            read_chk(tbl[i].addr, $sformatf("tbl%0d_rd", i), tbl[i].exp);
            tick();
         end
      end

      // Load back buffer, enable with swap, observe first frames
      do_reset();
      for (int r = 0; r < 16; r++) bus_write(5'(r), 16'h0001 << r);
      bus_write(5'd16, 16'h0003);
      fs_n = 0; nz1 = 0; nz2 = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (frame_start && fs_n < 4) begin
            fs_t[fs_n] = cyc;
            fs_n++;
         end
         if (fs_n == 1 && col_data != 0) nz1++;
         if (fs_n == 2 && col_data != 0 && col_data == row_sel) nz2++;
      end
      check("fs_count", fs_n, 4);
      check("fs_period1", fs_t[1] - fs_t[0], FRM);
      check("fs_period2", fs_t[2] - fs_t[1], FRM);
      check("frame1_blank", nz1, 0);
      check("frame2_drive_cycles", nz2, 16 * RC);

      // Swap request in the exact boundary cycle is deferred one frame
      found = 0;
      for (int i = 0; i < FRM + 2 && !found; i++) begin
         if (m_k >= 0 && (m_k % FRM) == FRM - 1) found = 1;
         else tick();
      end
      if (!found) timeout_fail("wait_boundary");
      bus_write(5'd16, 16'h0003);
      read_chk(5'd17, "status_boundary_write", 16'h0101);
      tick();
      found = 0;
      for (int i = 0; i < FRM + 2 && !found; i++) begin
         if (frame_start) found = 1;
         else tick();
      end
      if (!found) timeout_fail("wait_next_frame");
      read_chk(5'd17, "status_after_swap", 16'h0000);

      // Clear enable mid-drive of row 7 with a swap request, then re-enable
      found = 0;
      for (int i = 0; i < FRM + 2 && !found; i++) begin
         if (m_k >= 0 && (m_k % FRM) == 7 * PER + BC + 1) found = 1;
         else tick();
      end
      if (!found) timeout_fail("wait_row7");
      bus_write(5'd16, 16'h0002);
      tick();
      check("disable_rowsel", {16'b0, row_sel}, 32'h0);
      check("disable_col", {16'b0, col_data}, 32'h0);
      repeat (3) tick();
      read_chk(5'd17, "status_disabled", 16'h0001);
      bus_write(5'd16, 16'h0001);
      tick();
      check("restart_fs", {31'b0, frame_start}, 32'h1);
      check("restart_rowsel", {16'b0, row_sel}, 32'h0);
      tick();
      found = 0;
      for (int i = 0; i < FRM + 2 && !found; i++) begin
         if (frame_start) found = 1;
         else tick();
      end
      if (!found) timeout_fail("wait_reenable_frame");
      read_chk(5'd17, "status_reenable_swap", 16'h0100);

      // Asynchronous reset while driving
      found = 0;
      for (int i = 0; i < PER + 2 && !found; i++) begin
         if (m_k >= 0 && (m_k % PER) == BC + 1) found = 1;
         else tick();
      end
      if (!found) timeout_fail("wait_drive");
      check("pre_reset_driving", {31'b0, (row_sel != 0)}, 32'h1);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_out", {row_sel, col_data}, 32'h0);
      check("async_rst_fs", {31'b0, frame_start}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int a = 0; a < 16; a++) read_chk(5'(a), "rst_bank", 16'h0000);
      read_chk(5'd16, "rst_ctrl", 16'h0000);
      read_chk(5'd17, "rst_status", 16'h0000);

      // Randomized bus traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         int sel;
         sel = $urandom_range(0, 99);
         bus_idle();
         address   = 5'($urandom_range(0, 31));
         writedata = 16'($urandom);
         if (sel < 25) begin
            chipselect = 1'b1; write_n = 1'b0;
            address    = 5'($urandom_range(0, 15));
         end else if (sel < 29) begin
            chipselect = 1'b1; write_n = 1'b0;
            address    = 5'd16;
            writedata  = {14'($urandom), 1'($urandom), 1'($urandom_range(0, 9) != 0)};
         end else if (sel < 31) begin
            chipselect = 1'b1; write_n = 1'b0;
            address    = 5'($urandom_range(18, 31));
         end else if (sel < 34) begin
            chipselect = 1'b0; write_n = 1'b0;
         end
         #1;
         check("rand_readdata", {16'b0, readdata}, {16'b0, model_rd(address)});
         tick();
      end
      bus_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
